// File: rtl/ysyx_23060072_pkg.sv
// Shared types and constants for the ysyx_23060072 pipeline hazard control.
package ysyx_23060072_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazard_state_t;

    localparam int DEFAULT_CNT_W = 32;

endpackage

// File: rtl/ysyx_23060072_sat_cnt.sv
// Enable-driven up counter that sticks at all-ones instead of wrapping.
module ysyx_23060072_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/ysyx_23060072_hazard_ctrl.sv
// Pipeline stall/flush arbitration with a memory-wait watchdog.
// Performance counters exist only when HAZARD_PERF_CNT_EN is defined.
module ysyx_23060072_hazard_ctrl
    import ysyx_23060072_pkg::*;
#(
    parameter int WDT_MAX = 255,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             ex_redirect,
    input  logic             lsu_req,
    input  logic             lsu_rvalid,
    output logic             pc_stall,
    output logic             if2id_stall,
    output logic             id2ex_stall,
    output logic             ex2lsu_stall,
    output logic             if2id_flush,
    output logic             id2ex_flush,
    output logic             lsu2wb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] wait_cnt,
    output logic [CNT_W-1:0] redir_cnt
);

    localparam int WDT_W = $clog2(WDT_MAX + 1);

    hazard_state_t    state;
    logic [WDT_W-1:0] wdt;
    logic [WDT_W-1:0] wdt_inc;
    logic             run_miss;
    logic             wait_hold;
    logic             wdt_expire;
    logic             mem_stall;
    logic             redir_act;
    logic             lu_act;

    assign wdt_inc    = wdt + WDT_W'(1);
    assign run_miss   = (state == RUN) && lsu_req && !lsu_rvalid;
    assign wait_hold  = (state == MEM_WAIT) && !lsu_rvalid;
    assign wdt_expire = wait_hold && (wdt_inc == WDT_W'(WDT_MAX));

    // Outputs are gated by rst_n so nothing leaks out while reset is held.
    assign mem_stall = rst_n && (run_miss || wait_hold);
    assign redir_act = rst_n && !mem_stall && ex_redirect;
    assign lu_act    = rst_n && !mem_stall && !ex_redirect && load_use;

    assign pc_stall     = mem_stall || lu_act;
    assign if2id_stall  = mem_stall || lu_act;
    assign id2ex_stall  = mem_stall;
    assign ex2lsu_stall = mem_stall;
    assign if2id_flush  = redir_act;
    assign id2ex_flush  = redir_act || lu_act;
    assign lsu2wb_flush = mem_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wdt         <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (run_miss) begin
                        state <= MEM_WAIT;
                        wdt   <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (lsu_rvalid) begin
                        state <= RUN;
                    end else if (wdt_expire) begin
                        state       <= RUN;
                        wdt         <= wdt_inc;
                        mem_timeout <= 1'b1;
                    end else begin
                        wdt <= wdt_inc;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    ysyx_23060072_sat_cnt #(.W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lu_act),
        .cnt   (lu_cnt)
    );

    ysyx_23060072_sat_cnt #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mem_stall),
        .cnt   (wait_cnt)
    );

    ysyx_23060072_sat_cnt #(.W(CNT_W)) u_redir_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (redir_act),
        .cnt   (redir_cnt)
    );
`else
    assign lu_cnt    = '0;
    assign wait_cnt  = '0;
    assign redir_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060072_hazard_ctrl.sv
// Self-checking bench for ysyx_23060072_hazard_ctrl against a cycle-level
// behavioural model; counter expectations follow HAZARD_PERF_CNT_EN.
module tb_ysyx_23060072_hazard_ctrl;

    localparam int WDT = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_use, ex_redirect, lsu_req, lsu_rvalid;
    logic          pc_stall, if2id_stall, id2ex_stall, ex2lsu_stall;
    logic          if2id_flush, id2ex_flush, lsu2wb_flush, mem_timeout;
    logic [CW-1:0] lu_cnt, wait_cnt, redir_cnt;

    int checks   = 0;
    int failures = 0;

    // Model state: is an access outstanding, how many wait cycles have elapsed.
    bit m_pending;
    int m_waited;
    bit m_to;
    int m_lu, m_wait, m_redir;
    bit e_stall, e_redir, e_lu, e_tonow;

    ysyx_23060072_hazard_ctrl #(.WDT_MAX(WDT), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_use     (load_use),
        .ex_redirect  (ex_redirect),
        .lsu_req      (lsu_req),
        .lsu_rvalid   (lsu_rvalid),
        .pc_stall     (pc_stall),
        .if2id_stall  (if2id_stall),
        .id2ex_stall  (id2ex_stall),
        .ex2lsu_stall (ex2lsu_stall),
        .if2id_flush  (if2id_flush),
        .id2ex_flush  (id2ex_flush),
        .lsu2wb_flush (lsu2wb_flush),
        .mem_timeout  (mem_timeout),
        .lu_cnt       (lu_cnt),
        .wait_cnt     (wait_cnt),
        .redir_cnt    (redir_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] cnt_exp(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return CW'((v > SAT) ? SAT : v);
`else
        return CW'(v & 0);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        logic [6:0] obs, exp;
        obs = {pc_stall, if2id_stall, id2ex_stall, ex2lsu_stall,
               if2id_flush, id2ex_flush, lsu2wb_flush};
        if (!rst_n) begin
            exp = '0;
        end else begin
            exp = {e_stall | e_lu, e_stall | e_lu, e_stall, e_stall,
                   e_redir, e_redir | e_lu, e_stall};
        end
        check({tag, ".ctl"}, 32'(obs), 32'(exp));
        check({tag, ".timeout"}, 32'(mem_timeout), 32'(m_to));
        check({tag, ".lu_cnt"}, 32'(lu_cnt), 32'(cnt_exp(m_lu)));
        check({tag, ".wait_cnt"}, 32'(wait_cnt), 32'(cnt_exp(m_wait)));
        check({tag, ".redir_cnt"}, 32'(redir_cnt), 32'(cnt_exp(m_redir)));
    endtask

    task automatic modelReset();
        m_pending = 0; m_waited = 0; m_to = 0;
        m_lu = 0; m_wait = 0; m_redir = 0;
    endtask

    // One clock cycle: drive, predict, compare, then advance the model.
    task automatic applyStimulus(input string tag, input bit lu, input bit rd,
                                 input bit rq, input bit rv);
        @(negedge clk);
        load_use = lu; ex_redirect = rd; lsu_req = rq; lsu_rvalid = rv;
        e_stall = m_pending ? !rv : (rq && !rv);
        e_tonow = m_pending && !rv && (m_waited + 1 == WDT);
        e_redir = !e_stall && rd;
        e_lu    = !e_stall && !rd && lu;
        #1;
        checkAll(tag);
        @(posedge clk);
        if (e_stall) m_wait++;
        if (e_redir) m_redir++;
        if (e_lu)    m_lu++;
        if (m_pending) begin
            if (rv) m_pending = 0;
            else if (e_tonow) begin m_pending = 0; m_to = 1; end
            else m_waited++;
        end else if (e_stall) begin
            m_pending = 1; m_waited = 0;
        end
    endtask

    // Pulse reset mid-cycle with busy inputs; outputs must all read zero.
    task automatic checkOutput(input string tag);
        @(negedge clk);
        load_use = 1; ex_redirect = 1; lsu_req = 1; lsu_rvalid = 0;
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkAll(tag);
        @(negedge clk);
        load_use = 0; ex_redirect = 0; lsu_req = 0; lsu_rvalid = 0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        load_use = 0; ex_redirect = 0; lsu_req = 0; lsu_rvalid = 0;
        e_stall = 0; e_redir = 0; e_lu = 0; e_tonow = 0;
        modelReset();
        #3;
        checkAll("reset");
        #14 rst_n = 1'b1;

        applyStimulus("idle", 0, 0, 0, 0);
        applyStimulus("lu1", 1, 0, 0, 0);
        applyStimulus("lu1_after", 0, 0, 0, 0);
        check("lu1_cnt", 32'(lu_cnt), 32'(cnt_exp(1)));

        checkOutput("rst_a");
        applyStimulus("mw_req", 0, 0, 1, 0);
        applyStimulus("mw_w1", 0, 0, 1, 0);
        applyStimulus("mw_w2", 0, 0, 1, 0);
        applyStimulus("mw_resp", 0, 0, 1, 1);
        applyStimulus("mw_after", 0, 0, 0, 0);
        check("mw_wait_cnt", 32'(wait_cnt), 32'(cnt_exp(3)));
        applyStimulus("zero_wait", 1, 0, 1, 1);

        checkOutput("rst_b");
        applyStimulus("rd_vs_lu", 1, 1, 0, 0);
        applyStimulus("rd_vs_lu_after", 0, 0, 0, 0);
        check("rd_vs_lu_redir", 32'(redir_cnt), 32'(cnt_exp(1)));
        check("rd_vs_lu_lu", 32'(lu_cnt), 32'(cnt_exp(0)));

        applyStimulus("rdw_req", 1, 1, 1, 0);
        applyStimulus("rdw_w1", 1, 1, 0, 0);
        applyStimulus("rdw_resp", 1, 1, 0, 1);

        checkOutput("rst_c");
        applyStimulus("to_req", 0, 0, 1, 0);
        for (int i = 0; i < WDT + 3; i++) applyStimulus("to_wait", 0, 1, 0, 0);
        check("to_sticky", 32'(mem_timeout), 32'd1);
        applyStimulus("to_lu", 1, 0, 0, 0);

        checkOutput("rst_mid_wait");
        applyStimulus("rmw_req", 0, 0, 1, 0);
        applyStimulus("rmw_w1", 0, 0, 0, 0);
        checkOutput("rst_in_wait");
        applyStimulus("rmw_idle1", 0, 0, 0, 0);
        applyStimulus("rmw_idle2", 0, 0, 0, 0);

        for (int i = 0; i < 20; i++) applyStimulus("sat_lu", 1, 0, 0, 0);
        check("sat_lu_cnt", 32'(lu_cnt), 32'(cnt_exp(20)));

        checkOutput("rst_d");
        for (int i = 0; i < 300; i++) begin
            applyStimulus("rand",
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 3) == 0));
            if ((i % 100) == 99) checkOutput("rand_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060072_hazard_ctrl.md
YSYX_23060072_HAZARD_CTRL -- requirements
Module: ysyx_23060072_hazard_ctrl

Interface
REQ-001 SHALL have parameter WDT_MAX, default 255: maximum MEM_WAIT cycles before timeout.
REQ-002 SHALL have parameter CNT_W, default 32: width of each performance counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port load_use, input, 1 bit: load-use hazard flag from the forwarding unit (load in EX/LSU, dependent consumer in ID/EX).
REQ-007 SHALL have port ex_redirect, input, 1 bit: taken branch or jump resolved in EX.
REQ-008 SHALL have port lsu_req, input, 1 bit: LSU issues a memory access this cycle.
REQ-009 SHALL have port lsu_rvalid, input, 1 bit: memory response valid.
REQ-010 SHALL have ports pc_stall, if2id_stall, id2ex_stall and ex2lsu_stall, each output, 1 bit: hold the named register.
REQ-011 SHALL have ports if2id_flush, id2ex_flush and lsu2wb_flush, each output, 1 bit: load a bubble into the named register.
REQ-012 SHALL have port mem_timeout, output, 1 bit: sticky watchdog error.
REQ-013 SHALL have ports lu_cnt, wait_cnt and redir_cnt, each output, CNT_W bits: performance counters.

Function
REQ-014 SHALL implement FSM states RUN and MEM_WAIT; all stall and flush outputs are combinational from state and inputs.
REQ-015 In RUN with lsu_req=1 and lsu_rvalid=0, SHALL assert all four stalls plus lsu2wb_flush that cycle and enter MEM_WAIT.
REQ-016 In RUN with lsu_req=1 and lsu_rvalid=1, SHALL stay in RUN with no memory stall (zero-wait access).
REQ-017 In MEM_WAIT, SHALL assert all four stalls and lsu2wb_flush; ex_redirect and load_use are ignored.
REQ-018 In MEM_WAIT with lsu_rvalid=1, SHALL deassert every memory stall in that same cycle, evaluate redirect and load-use as in RUN, and return to RUN.
REQ-019 In RUN with no memory stall and ex_redirect=1, SHALL assert if2id_flush and id2ex_flush with no stalls; this overrides load_use in the same cycle.
REQ-020 In RUN with no memory stall, ex_redirect=0 and load_use=1, SHALL assert pc_stall, if2id_stall and id2ex_flush for exactly that cycle.
REQ-021 Priority SHALL be: memory wait > redirect > load-use.
REQ-022 Watchdog SHALL clear on entry to MEM_WAIT and increment on each MEM_WAIT cycle without lsu_rvalid.
REQ-023 When the watchdog reaches WDT_MAX, SHALL set mem_timeout (held until reset), return to RUN, and assert lsu2wb_flush that cycle.
REQ-024 lu_cnt SHALL count cycles that take the REQ-020 action.
REQ-025 wait_cnt SHALL count cycles with memory stalls asserted.
REQ-026 redir_cnt SHALL count cycles that take the REQ-019 action.
REQ-027 All counters SHALL saturate at all-ones and never wrap.

Reset
REQ-028 While rst_n=0: state SHALL be RUN; watchdog, mem_timeout and all counters SHALL be 0; all stall and flush outputs SHALL be 0.
REQ-029 Reset asserted during MEM_WAIT SHALL abandon the pending access with no further stall after release.

Configuration
REQ-030 With macro HAZARD_PERF_CNT_EN defined, SHALL implement the three counters per REQ-024 to REQ-027.
REQ-031 Without HAZARD_PERF_CNT_EN, the counter ports SHALL remain present and tied to 0, with no counter flops.

Structure
REQ-032 Package ysyx_23060072_pkg SHALL hold the FSM state typedef (RUN, MEM_WAIT) and a default CNT_W constant.
REQ-033 SHALL instantiate sub-module ysyx_23060072_sat_cnt (enable, saturating, CNT_W wide) once per counter.

Verification
REQ-034 Single load-use: load_use=1 for 1 cycle in RUN -> pc_stall=1, if2id_stall=1, id2ex_flush=1 for 1 cycle; lu_cnt=1.
REQ-035 Memory wait: lsu_req=1, lsu_rvalid arrives 3 cycles later -> all stalls high for 3 cycles, then low in the response cycle; wait_cnt=3.
REQ-036 Redirect vs load-use: ex_redirect=1 with load_use=1 -> if2id_flush=1, id2ex_flush=1, pc_stall=0; redir_cnt=1, lu_cnt=0.
REQ-037 Redirect during wait: ex_redirect held high through a 2-cycle wait -> no flush during the wait; flushes in the lsu_rvalid cycle.
REQ-038 Timeout: WDT_MAX=4, lsu_req with no response -> mem_timeout rises after 4 wait cycles and stays high; state returns to RUN.
REQ-039 Reset mid-wait and saturation: rst_n pulse in MEM_WAIT -> all outputs 0; with CNT_W=4, 20 load-use cycles -> lu_cnt=15.
